// File: rtl/input_wrapper.sv
`timescale 1ns/1ps
// Assembles two bus bytes (high first) into a 16-bit operand and hands it to the sine engine;
// start pulses 1 cycle after the low byte; ready drops from start until done, late bytes set ovf.
module input_wrapper #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bus,
  input  logic        inReady,
  input  logic        done,
  output logic [15:0] x,
  output logic        start,
  output logic        ready,
  output logic [7:0]  word_cnt,
  output logic        ovf,
  output logic        tmo
);

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    START   = 2'd2,
    BUSY    = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic        start_q;
  logic        ready_c;

  assign ready_c = (state_q == WAIT_HI) || (state_q == WAIT_LO);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;

    case (state_q)
      WAIT_HI: begin
        if (inReady) begin
          x_d[15:8] = bus;
          timer_d   = 8'd0;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A low byte landing on the timeout cycle still completes the word.
        if (inReady) begin
          x_d[7:0] = bus;
          state_d  = START;
        end else if (timer_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = WAIT_HI;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      START: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = BUSY;
      end
      BUSY: begin
        if (done) begin
          state_d = WAIT_HI;
        end
      end
      default: begin
        state_d = WAIT_HI;
      end
    endcase

    // Bytes offered while the engine owns x are dropped and only flagged.
    if (inReady && !ready_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HI;
      x_q     <= 16'd0;
      timer_q <= 8'd0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      start_q <= (state_d == START);
    end
  end

  assign x        = x_q;
  assign start    = start_q;
  assign ready    = ready_c;
  assign word_cnt = cnt_q;
  assign ovf      = ovf_q;
  assign tmo      = tmo_q;

endmodule

// File: doc/input_wrapper.md
INPUT_WRAPPER -- requirements
Module: input_wrapper

Interface
REQ-001 The block SHALL have one parameter: TMO_CYCLES, default 255, the maximum number of idle cycles allowed between the high and low byte of a word (range 1..255).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 bus  input  8  byte from the shared 8-bit bus.
REQ-005 inReady  input  1  source strobe; bus holds a valid byte this cycle.
REQ-006 done  input  1  sine engine finished the current x; single-cycle pulse.
REQ-007 x  output  16  assembled operand to the sine engine.
REQ-008 start  output  1  one-cycle pulse; x is valid and the engine SHALL begin.
REQ-009 ready  output  1  the block accepts a byte this cycle.
REQ-010 word_cnt  output  8  count of words handed to the engine, wrapping modulo 256.
REQ-011 ovf  output  1  sticky flag; a byte arrived while the block was not ready.
REQ-012 tmo  output  1  sticky flag; a word was aborted because its low byte timed out.

Function
REQ-013 The FSM SHALL have exactly four states: WAIT_HI, WAIT_LO, START, BUSY.
REQ-014 Byte order SHALL be high byte first, then low byte.
REQ-015 WAIT_HI with inReady=1: x[15:8] <= bus; go to WAIT_LO; timer <= 0.
REQ-016 WAIT_HI with inReady=0: hold state.
REQ-017 WAIT_LO with inReady=1: x[7:0] <= bus; go to START.
REQ-018 WAIT_LO with inReady=0: timer increments by 1.
REQ-019 WAIT_LO with inReady=0 and timer==TMO_CYCLES-1: go to WAIT_HI; tmo <= 1; x unchanged.
REQ-020 In WAIT_LO, inReady=1 SHALL take priority over timeout when both occur in the same cycle.
REQ-021 START: start=1 for exactly one cycle; word_cnt increments by 1 (255 wraps to 0); go to BUSY unconditionally.
REQ-022 done SHALL be ignored in the START cycle.
REQ-023 BUSY with done=1: go to WAIT_HI.
REQ-024 BUSY with done=0: hold state.
REQ-025 x SHALL remain stable from START until the exit from BUSY.
REQ-026 ready SHALL be combinationally 1 in WAIT_HI and WAIT_LO, and 0 in START and BUSY.
REQ-027 inReady=1 while ready=0 SHALL set ovf.
REQ-028 A byte received while ready=0 SHALL be discarded without changing x or the state.
REQ-029 ovf and tmo SHALL clear only on reset.
REQ-030 start SHALL be a registered decode of the START state, with no combinational path from any input.
REQ-031 Latency from the low-byte inReady edge to start=1 SHALL be exactly 1 cycle.
REQ-032 The minimum time from one word's start to the next word's start SHALL be 4 cycles, counted with done arriving in the first BUSY cycle.

Reset
REQ-033 On rst=1 at a clock edge: state <= WAIT_HI; x <= 0; timer <= 0; word_cnt <= 0; ovf <= 0; tmo <= 0; start reads 0; ready reads 1.
REQ-034 rst SHALL take priority over every other input, in any state.
REQ-035 Reset mid-word SHALL discard any partial byte; no start SHALL follow.
REQ-036 rst asserted in BUSY SHALL return the block to WAIT_HI without waiting for done.

Verification
REQ-037 Normal word: from reset, send bytes 0x12 then 0x34 on consecutive cycles -> x=0x1234, start high for 1 cycle, exactly 1 cycle after the second byte, word_cnt=1.
REQ-038 Overrun: in BUSY, pulse inReady with bus=0xFF -> ovf=1, x unchanged; then done=1 -> WAIT_HI and ready=1; ovf stays 1.
REQ-039 Timeout: TMO_CYCLES=4, send high byte 0xAB, then hold inReady=0 -> tmo=1 and back in WAIT_HI after 4 idle cycles; next bytes 0x00,0x01 -> x=0x0001.
REQ-040 Timeout tie: low byte arrives on the exact timeout cycle -> word accepted, start pulses, tmo stays 0.
REQ-041 Wrap: complete 256 words -> word_cnt returns to 0 and no flags are set.
REQ-042 Reset mid-operation: rst asserted in WAIT_LO, and separately in BUSY -> all outputs at reset values next cycle; no start pulse.
